// File: rtl/snn_output_decoder.sv
// Output decoder for the SNN: accumulates per-class spike counts over a
// programmable window of timesteps and hands the argmax class over valid/ready.
module snn_output_decoder #(
  parameter int NUM_CLASSES  = 2,
  parameter int COUNT_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 8,
  localparam int ID_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_enable,
  input  logic                               i_start,
  input  logic                               i_timestep_tick,
  input  logic [NUM_CLASSES-1:0]             i_output_spikes,
  input  logic [WINDOW_WIDTH-1:0]            i_window_len,
  input  logic [COUNT_WIDTH-1:0]             i_min_count,
  output logic                               o_net_clear,
  output logic                               o_busy,
  output logic                               o_class_valid,
  input  logic                               i_class_ready,
  output logic [ID_W-1:0]                    o_class_id,
  output logic                               o_no_decision,
  output logic [NUM_CLASSES*COUNT_WIDTH-1:0] o_counts_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_VALID  = 2'd3;

  logic [1:0]                         r_state;
  logic [COUNT_WIDTH-1:0]             r_cnt [NUM_CLASSES];
  logic [WINDOW_WIDTH-1:0]            r_tick_cnt;
  logic [WINDOW_WIDTH-1:0]            r_win_len;
  logic [COUNT_WIDTH-1:0]             r_min_count;
  logic                               r_net_clear;
  logic [ID_W-1:0]                    r_class_id;
  logic                               r_no_decision;
  logic [NUM_CLASSES*COUNT_WIDTH-1:0] r_counts_out;

  logic [ID_W-1:0]                    w_best_id;
  logic [COUNT_WIDTH-1:0]             w_best_cnt;
  logic [WINDOW_WIDTH-1:0]            w_tick_nxt;

  assign w_tick_nxt = r_tick_cnt + WINDOW_WIDTH'(1);

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_best_id  = '0;
    w_best_cnt = r_cnt[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (r_cnt[i] > w_best_cnt) begin
        w_best_cnt = r_cnt[i];
        w_best_id  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_tick_cnt    <= '0;
      r_win_len     <= '0;
      r_min_count   <= '0;
      r_net_clear   <= 1'b0;
      r_class_id    <= '0;
      r_no_decision <= 1'b0;
      r_counts_out  <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
    end else begin
      r_net_clear <= 1'b0;
      if (i_enable) begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_tick_cnt  <= '0;
              r_win_len   <= i_window_len;
              r_min_count <= i_min_count;
              r_net_clear <= 1'b1;
              for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
              r_state <= (i_window_len == '0) ? S_DECIDE : S_ACCUM;
            end
          end
          S_ACCUM: begin
            if (i_timestep_tick) begin
              for (int i = 0; i < NUM_CLASSES; i++) begin
                if (i_output_spikes[i] && (r_cnt[i] != {COUNT_WIDTH{1'b1}}))
                  r_cnt[i] <= r_cnt[i] + COUNT_WIDTH'(1);
              end
              r_tick_cnt <= w_tick_nxt;
              if (w_tick_nxt == r_win_len) r_state <= S_DECIDE;
            end
          end
          S_DECIDE: begin
            r_class_id    <= w_best_id;
            r_no_decision <= (w_best_cnt < r_min_count);
            for (int i = 0; i < NUM_CLASSES; i++)
              r_counts_out[i*COUNT_WIDTH +: COUNT_WIDTH] <= r_cnt[i];
            r_state <= S_VALID;
          end
          default: begin
            if (i_class_ready) r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_net_clear   = r_net_clear;
  assign o_busy        = (r_state == S_ACCUM) || (r_state == S_DECIDE);
  assign o_class_valid = (r_state == S_VALID);
  assign o_class_id    = r_class_id;
  assign o_no_decision = r_no_decision;
  assign o_counts_out  = r_counts_out;

endmodule

// File: tb/tb_snn_output_decoder.sv
// Directed bench for snn_output_decoder; a narrow-counter instance shares the
// stimulus so that counter saturation is exercised within a 255-tick window.
module tb_snn_output_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        start;
  logic        tick;
  logic [1:0]  spikes;
  logic [7:0]  window_len;
  logic [7:0]  min_count;
  logic        class_ready;

  logic        net_clear, busy, class_valid, class_id, no_decision;
  logic [15:0] counts_out;
  logic        n_net_clear, n_busy, n_class_valid, n_class_id, n_no_decision;
  logic [3:0]  n_counts_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snn_output_decoder #(.NUM_CLASSES(2), .COUNT_WIDTH(8), .WINDOW_WIDTH(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_start(start),
    .i_timestep_tick(tick), .i_output_spikes(spikes), .i_window_len(window_len),
    .i_min_count(min_count), .o_net_clear(net_clear), .o_busy(busy),
    .o_class_valid(class_valid), .i_class_ready(class_ready),
    .o_class_id(class_id), .o_no_decision(no_decision), .o_counts_out(counts_out)
  );

  snn_output_decoder #(.NUM_CLASSES(2), .COUNT_WIDTH(2), .WINDOW_WIDTH(8)) dut_n (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_start(start),
    .i_timestep_tick(tick), .i_output_spikes(spikes), .i_window_len(window_len),
    .i_min_count(min_count[1:0]), .o_net_clear(n_net_clear), .o_busy(n_busy),
    .o_class_valid(n_class_valid), .i_class_ready(class_ready),
    .o_class_id(n_class_id), .o_no_decision(n_no_decision), .o_counts_out(n_counts_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic [1:0] s);
    tick = 1'b1;
    spikes = s;
    cyc();
    tick = 1'b0;
    spikes = 2'b00;
  endtask

  task automatic open_window(input logic [7:0] wl, input logic [7:0] mc);
    window_len = wl;
    min_count = mc;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic handshake(input string tag);
    class_ready = 1'b1;
    cyc();
    class_ready = 1'b0;
    chk({tag, "_valid_drop"}, class_valid, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; start = 1'b0; tick = 1'b0; spikes = 2'b00;
    window_len = 8'd0; min_count = 8'd0; class_ready = 1'b0;
    #1;
    chk("rst_valid", class_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counts", counts_out, 0);
    chk("rst_net_clear", net_clear, 0);
    repeat (2) cyc();
    rst = 1'b0;
    enable = 1'b1;
    cyc();

    // basic window
    open_window(8'd4, 8'd1);
    chk("basic_net_clear", net_clear, 1);
    chk("basic_busy", busy, 1);
    do_tick(2'b01);
    chk("basic_net_clear_once", net_clear, 0);
    do_tick(2'b11);
    do_tick(2'b01);
    do_tick(2'b00);
    chk("basic_decide_valid", class_valid, 0);
    chk("basic_decide_busy", busy, 1);
    cyc();
    chk("basic_valid", class_valid, 1);
    chk("basic_busy_off", busy, 0);
    chk("basic_counts", counts_out, 16'h0103);
    chk("basic_id", class_id, 0);
    chk("basic_nodec", no_decision, 0);
    handshake("basic");

    // tie below threshold, then backpressure
    open_window(8'd3, 8'd4);
    repeat (3) do_tick(2'b11);
    cyc();
    chk("tie_valid", class_valid, 1);
    chk("tie_counts", counts_out, 16'h0303);
    chk("tie_id", class_id, 0);
    chk("tie_nodec", no_decision, 1);
    chk("tie_n_counts", n_counts_out, 4'hF);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid", class_valid, 1);
      chk("bp_counts", counts_out, 16'h0303);
      chk("bp_nodec", no_decision, 1);
    end
    handshake("bp");
    chk("idle_hold_counts", counts_out, 16'h0303);

    // enable gating
    open_window(8'd2, 8'd1);
    do_tick(2'b10);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) do_tick(2'b11);
    chk("gate_busy", busy, 1);
    enable = 1'b1;
    do_tick(2'b10);
    cyc();
    chk("gate_valid", class_valid, 1);
    chk("gate_counts", counts_out, 16'h0200);
    chk("gate_id", class_id, 1);
    chk("gate_nodec", no_decision, 0);
    handshake("gate");

    // long window: wide instance reaches 255, narrow instance saturates at 3
    open_window(8'd255, 8'd0);
    for (int i = 0; i < 254; i++) do_tick(2'b10);
    chk("sat_still_busy", busy, 1);
    do_tick(2'b10);
    cyc();
    chk("sat_valid", class_valid, 1);
    chk("sat_counts", counts_out, 16'hFF00);
    chk("sat_id", class_id, 1);
    chk("sat_n_counts", n_counts_out, 4'hC);
    chk("sat_n_id", n_class_id, 1);
    handshake("sat");

    // zero-length window
    open_window(8'd0, 8'd1);
    chk("wl0_net_clear", net_clear, 1);
    chk("wl0_busy", busy, 1);
    cyc();
    chk("wl0_valid", class_valid, 1);
    chk("wl0_counts", counts_out, 16'h0000);
    chk("wl0_nodec", no_decision, 1);
    chk("wl0_id", class_id, 0);
    handshake("wl0");

    // back-to-back with start held high
    window_len = 8'd1;
    min_count = 8'd1;
    start = 1'b1;
    cyc();
    chk("b2b_net_clear1", net_clear, 1);
    do_tick(2'b01);
    cyc();
    chk("b2b_valid1", class_valid, 1);
    chk("b2b_counts1", counts_out, 16'h0001);
    cyc();
    chk("b2b_hold_valid", class_valid, 1);
    chk("b2b_no_restart", net_clear, 0);
    handshake("b2b1");
    chk("b2b_idle_net_clear", net_clear, 0);
    cyc();
    chk("b2b_net_clear2", net_clear, 1);
    chk("b2b_busy2", busy, 1);
    do_tick(2'b10);
    cyc();
    chk("b2b_counts2", counts_out, 16'h0100);
    chk("b2b_id2", class_id, 1);
    start = 1'b0;
    handshake("b2b2");

    // async reset mid-window
    open_window(8'd10, 8'd1);
    do_tick(2'b11);
    do_tick(2'b01);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", class_valid, 0);
    chk("midrst_counts", counts_out, 0);
    chk("midrst_net_clear", net_clear, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("postrst_net_clear", net_clear, 0);
    chk("postrst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
